// File: rtl/sum_acc_pkg.sv
// Shared types and defaults for the sum stream accumulator.
package sum_acc_pkg;

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_e;

  localparam int COUNT_W     = 8;
  localparam int DEF_D_WIDTH = 6;
  localparam int DEF_ACC_LEN = 4;
  localparam int DEF_A_WIDTH = 8;

endpackage

// File: rtl/sum_stream_accumulator_sat_adder.sv
// W-bit adder with an optional clamp at all-ones; clamp flags a saturated add.
module sat_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sat_en,
  output logic [W-1:0] sum,
  output logic         clamp
);

  logic [W:0] raw;

  assign raw   = {1'b0, a} + {1'b0, b};
  assign clamp = sat_en & raw[W];
  assign sum   = clamp ? '1 : raw[W-1:0];

endmodule

// File: rtl/sum_stream_accumulator.sv
// Pops sums from a FWFT FIFO head, reduces ACC_LEN of them (or fewer on flush)
// into one A_WIDTH total and offers it on a valid/ready port.
// Optional feature macro: SATURATE_ACC_EN (saturating adds + out_sat flag).
// Without it adds wrap and out_sat stays constant 0.
module sum_stream_accumulator
  import sum_acc_pkg::*;
#(
  parameter int          D_WIDTH = DEF_D_WIDTH,
  parameter int unsigned ACC_LEN = DEF_ACC_LEN,
  parameter int          A_WIDTH = DEF_A_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] up_data,
  input  logic               up_valid,
  output logic               pop,
  input  logic               flush,
  output logic [A_WIDTH-1:0] out_data,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_sat,
  output logic               out_valid,
  input  logic               out_ready
);

`ifdef SATURATE_ACC_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  state_e             state;
  logic [A_WIDTH-1:0] acc;
  logic [COUNT_W-1:0] cnt;
  logic               sat_acc;

  logic [A_WIDTH-1:0] add_sum;
  logic               add_clamp;
  logic [A_WIDTH-1:0] acc_next;
  logic [COUNT_W-1:0] cnt_next;
  logic               sat_next;
  logic               complete;

  // HOLD frees the head only in the cycle the result is taken, so a new
  // group can start with no bubble. Gated by rst so reset never consumes.
  assign pop = rst && up_valid && (state == ACCUM || out_ready);

  sat_adder #(.W(A_WIDTH)) u_add (
    .a      (acc),
    .b      (A_WIDTH'(up_data)),
    .sat_en (SAT_EN),
    .sum    (add_sum),
    .clamp  (add_clamp)
  );

  assign acc_next = pop ? add_sum : acc;
  assign cnt_next = pop ? cnt + 1'b1 : cnt;
  assign sat_next = sat_acc | (pop & add_clamp);
  // cnt is always 0 in HOLD, so a flush there only fires alongside a pop.
  assign complete = (pop && cnt_next == COUNT_W'(ACC_LEN)) ||
                    (flush && cnt_next != '0);

  // Accumulate, emit finished groups and run the ACCUM/HOLD handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      sat_acc   <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
    end else if (complete) begin
      out_data  <= acc_next;
      out_count <= cnt_next;
      out_sat   <= sat_next;
      out_valid <= 1'b1;
      acc       <= '0;
      cnt       <= '0;
      sat_acc   <= 1'b0;
      state     <= HOLD;
    end else begin
      acc     <= acc_next;
      cnt     <= cnt_next;
      sat_acc <= sat_next;
      if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
        state     <= ACCUM;
      end
    end
  end

endmodule
